prescale_clk_div: RTL

- Parametrised receive-side clock generator for the UART oversampling path.
- Decodes the configured prescale (oversampling factor) into a divide ratio, using ratio = MAX_PRESCALE / prescale.
- Divides the reference clock by that ratio and produces the RX sampling clock. The ratio changes glitch-free, only at period boundaries.
- Sits between the register file (prescale field) and the UART RX.

---
 rtl/prescale_clk_div.sv | 125 ++++++++++++
 1 files changed

// File: rtl/prescale_clk_div.sv
`default_nettype none
// ============================================================================
// Module   : prescale_clk_div
// Function : RX oversampling clock generator, ratio = MAX_PRESCALE/prescale,
//            glitch-free ratio switching at period boundaries.
//            Optional sticky error flag enabled by `define PRESCALE_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module prescale_clk_div #(
  parameter int MAX_PRESCALE = 32,
  parameter int PRESCALE_W   = 6,
  parameter int DIV_W        = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clk_div_en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  div_clk,
  output logic [DIV_W-1:0]      div_ratio,
  output logic                  ratio_busy
`ifdef PRESCALE_ERR_EN
  ,
  output logic                  prescale_err
`endif
);

  localparam int c_log2_max = $clog2(MAX_PRESCALE);

  typedef enum logic [0:0] {
    S_BYPASS = 1'b0,
    S_RUN    = 1'b1
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] w_dec_ratio;
  logic [DIV_W-1:0] r_pend_ratio;
  logic [DIV_W-1:0] r_div_ratio;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_half_m1;
  logic             r_tog;
  logic             w_cnt_end;
  logic             w_boundary;

  // Only exact powers of two up to MAX_PRESCALE match; everything else is ratio 1.
  always_comb begin
    w_dec_ratio = DIV_W'(1);
    for (int i = 0; i <= c_log2_max; i++) begin
      if (prescale == PRESCALE_W'(1 << i)) begin
        w_dec_ratio = DIV_W'(MAX_PRESCALE >> i);
      end
    end
  end

  assign w_half_m1  = (r_div_ratio >> 1) - DIV_W'(1);
  assign w_cnt_end  = (r_cnt == w_half_m1);
  assign w_boundary = (r_state == S_RUN) && clk_div_en && r_tog && w_cnt_end;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= S_BYPASS;
      r_cnt        <= '0;
      r_tog        <= 1'b0;
      r_div_ratio  <= DIV_W'(1);
      r_pend_ratio <= DIV_W'(1);
    end else begin
      r_pend_ratio <= w_dec_ratio;
      case (r_state)
        S_BYPASS: begin
          r_cnt       <= '0;
          r_tog       <= 1'b0;
          r_div_ratio <= r_pend_ratio;
          if (clk_div_en && (r_pend_ratio >= DIV_W'(2))) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (!clk_div_en) begin
            r_state     <= S_BYPASS;
            r_cnt       <= '0;
            r_tog       <= 1'b0;
            r_div_ratio <= r_pend_ratio;
          end else if (w_cnt_end) begin
            r_cnt <= '0;
            r_tog <= ~r_tog;
            // Falling toggle closes the period: adopt the pending ratio here only.
            if (w_boundary) begin
              r_div_ratio <= r_pend_ratio;
              if (r_pend_ratio < DIV_W'(2)) begin
                r_state <= S_BYPASS;
              end
            end
          end else begin
            r_cnt <= r_cnt + DIV_W'(1);
          end
        end
        default: r_state <= S_BYPASS;
      endcase
    end
  end

  assign div_clk    = (r_state == S_RUN) ? r_tog : CLK;
  assign div_ratio  = r_div_ratio;
  assign ratio_busy = (r_pend_ratio != r_div_ratio);

`ifdef PRESCALE_ERR_EN
  logic w_dec_illegal;
  logic r_err;

  // Ratio 1 is legal only for prescale == MAX_PRESCALE.
  assign w_dec_illegal = (w_dec_ratio == DIV_W'(1)) &&
                         (prescale != PRESCALE_W'(MAX_PRESCALE));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_err <= 1'b0;
    end else if (w_dec_illegal) begin
      r_err <= 1'b1;
    end
  end

  assign prescale_err = r_err;
`endif

endmodule
`default_nettype wire
